cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Shares the single burst memory port of `mp4` between the instruction cache and the data cache miss/writeback paths. The block sits between the two caches' physical-memory interfaces and the top-level `mem_*` port. It serialises whole-cacheline transactions, latches the winning request, and routes the response back to the requester. It holds at most one outstanding transaction.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `LINE_W`, 256, cacheline width in bits

Ports (one clock; `rst` is an asynchronous, active-low reset):
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous active-low reset
- `i_read`  in  1  icache line-fill request
- `i_address`  in  ADDR_W  icache line address
- `i_rdata`  out  LINE_W  line returned to icache
- `i_resp`  out  1  icache transaction complete
- `d_read`  in  1  dcache line-fill request
- `d_write`  in  1  dcache writeback request
- `d_address`  in  ADDR_W  dcache line address
- `d_wdata`  in  LINE_W  writeback line
- `d_rdata`  out  LINE_W  line returned to dcache
- `d_resp`  out  1  dcache transaction complete
- `mem_read`, `mem_write`  out  1  burst memory commands
- `mem_address`  out  ADDR_W  burst memory address
- `mem_wdata`  out  LINE_W  burst write line
- `mem_rdata`  in  LINE_W  burst read line
- `mem_resp`  in  1  burst memory transaction complete

## Operation
- States: `IDLE`, `I_BUSY`, `D_BUSY`, `RECOVER`.
- `IDLE`:
  - Samples the requests each cycle.
  - On a grant, latches the address, the command (read/write) and `d_wdata` into registers, then moves to `I_BUSY` or `D_BUSY`.
  - With no requests it stays in `IDLE`.
- Tie-break when `i_read` and a dcache request are sampled together: the dcache wins (fixed priority; see Configuration).
- `d_read` and `d_write` asserted together is illegal. The write wins and the read is ignored.
- `I_BUSY` / `D_BUSY`:
  - Drive `mem_read` or `mem_write` from the latched command.
  - Drive `mem_address` and `mem_wdata` from the latched registers.
  - Requester-side changes are ignored until completion.
- Completion:
  - On `mem_resp`, the granted side's `*_resp` pulses in the same cycle (combinational).
  - `*_rdata` equals `mem_rdata` in that cycle.
  - The state then moves to `RECOVER`.
- `RECOVER`:
  - Lasts exactly one cycle, with both commands low.
  - This lets the requester drop its request so a stale request is never re-granted. The state then returns to `IDLE`.
- The non-granted requester is never given `*_resp`; it simply waits with its request held high.
- `i_rdata` and `d_rdata` are driven with `mem_rdata` continuously. Only the `*_resp` pulses are qualified.
- `mem_resp` arriving in `IDLE` or `RECOVER` is ignored.

## Timing
- Reset values: state `IDLE`; all latched registers 0; `mem_read`, `mem_write`, `i_resp` and `d_resp` all 0; `mem_address` and `mem_wdata` 0.
- Asserting `rst` mid-transaction abandons the transaction immediately. The memory model must be reset along with the arbiter.
- Latency, with the request first sampled in `IDLE` at cycle 0:
  - memory command is high from cycle 1
  - `mem_resp` arrives at cycle N ≥ 1, and `*_resp` is high at cycle N
  - `RECOVER` at cycle N+1, `IDLE` at cycle N+2
  - earliest next command at cycle N+3
- Memory commands are Moore outputs (a function of state and registers only). The `*_resp` pulses are Mealy outputs on `mem_resp`.
- Requesters hold their request and data stable until they see `*_resp`, and drop the request in the cycle after.

## Configuration
- `CACHELINE_ARBITER_RR_EN`:
  - When defined, tie-breaking is round-robin. A one-bit `last_grant` register (reset value: icache) is updated on every grant, and the requester not granted last wins a tie. The very first tie after reset therefore goes to the dcache.
  - When undefined, the dcache always wins ties and no `last_grant` flop exists.
- Non-tie behaviour is identical in both builds.

## Test plan
- Lone icache read: `i_read=1`, `i_address=0x60`, memory responds 4 cycles after the command with line `0xA5…A5`. Required: `mem_read=1` with `mem_address=0x60`; `i_resp` pulses one cycle with `i_rdata=0xA5…A5`; `d_resp` stays 0; `mem_read` is 0 in the cycle after.
- Dcache writeback: `d_write=1`, `d_address=0x100`, `d_wdata=0x1234…`. Required: `mem_write=1` with the same address and data; `d_resp` pulses when `mem_resp` arrives; `mem_read` is never asserted.
- Simultaneous requests: `i_read` and `d_read` both rise in the same cycle.
  - Fixed-priority build: the dcache is served first, then the icache, which is granted at cycle N+2 after the dcache response.
  - `CACHELINE_ARBITER_RR_EN` build: the order is dcache then icache on the first tie, and icache then dcache on the second tie.
- Request change mid-transaction: during `D_BUSY`, change `d_address` from 0x200 to 0x300. Required: `mem_address` stays 0x200 until the response.
- Reset mid-transaction: assert `rst` low while `I_BUSY`. Required: `mem_read`, `i_resp` and `d_resp` all go to 0 asynchronously; after release, the next `i_read` is granted from `IDLE` with normal latency.
- Illegal combination: `d_read` and `d_write` both high. Required: `mem_write=1`, `mem_read=0`.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// Shares one burst memory port between icache fills and dcache fills/writebacks, one line at a time.
// Command one cycle after a grant; *_resp combinational on mem_resp. CACHELINE_ARBITER_RR_EN selects round-robin ties.
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef CACHELINE_ARBITER_RR_EN
  // 1 = dcache was granted last; resets to icache so the first tie goes to the dcache.
  logic r_last_grant;

  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b0;
    end else if (r_state == IDLE && (w_i_req || w_d_req)) begin
      r_last_grant <= w_grant_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            r_addr      <= w_grant_d ? d_address : i_address;
            r_wdata     <= d_wdata;
            // a simultaneous d_read is dropped in favour of the writeback
            r_mem_write <= w_grant_d & d_write;
            r_mem_read  <= ~(w_grant_d & d_write);
            r_state     <= w_grant_d ? D_BUSY : I_BUSY;
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= RECOVER;
          end
        end
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;

  assign i_resp  = (r_state == I_BUSY) & mem_resp;
  assign d_resp  = (r_state == D_BUSY) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: expected transactions queued at stimulus, checked at command and response.
module tb_cacheline_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit            side;      // 1 = dcache
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            cmd_cyc;
    int            resp_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_lat = 4;
  int   mem_cnt = 0;
  bit   i_seen = 0;
  bit   d_seen = 0;
  bit   prev_cmd = 0;
  bit   after_resp = 0;
  bit   tie2_d_first;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {32{8'hA5}} ^ {8{a - 32'h60}};
  endfunction

  task automatic push(input bit side, input bit wr, input logic [AW-1:0] a,
                      input logic [LW-1:0] wd, input int cc, input int rc);
    exp_t e;
    e.side = side; e.wr = wr; e.addr = a; e.wdata = wd;
    e.rdata = line_of(a); e.cmd_cyc = cc; e.resp_cyc = rc;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // One cycle step: requesters drop after their response, memory model advances.
  task automatic tick();
    @(posedge clk);
    #1;
    if (i_seen) begin i_read = 1'b0; i_seen = 0; end
    if (d_seen) begin d_read = 1'b0; d_write = 1'b0; d_seen = 0; end
    if (!rst) begin
      mem_resp = 1'b0; mem_cnt = 0; mem_rdata = '0;
    end else if (mem_resp) begin
      mem_resp = 1'b0; mem_rdata = '0;
    end else if (mem_read || mem_write) begin
      mem_cnt++;
      if (mem_cnt > mem_lat) begin
        mem_resp = 1'b1; mem_rdata = line_of(mem_address); mem_cnt = 0;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || i_read || d_read || d_write) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      chk("timeout", 0, 1);
      exp_q.delete();
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
    tick();
  endtask

  // Two reads raised together: first served at c0+1, second granted after RECOVER.
  task automatic tie(input bit d_first, input logic [AW-1:0] ia, input logic [AW-1:0] da);
    int c0 = cyc;
    push(d_first, 0, d_first ? da : ia, '0, c0 + 1, c0 + 1 + mem_lat);
    push(!d_first, 0, d_first ? ia : da, '0, c0 + 4 + mem_lat, c0 + 4 + 2 * mem_lat);
    i_read = 1'b1; i_address = ia;
    d_read = 1'b1; d_address = da;
    wait_idle();
  endtask

  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_cmd = 0; after_resp = 0;
      end else begin
        if (after_resp) begin
          chk("recover_cmd_low", {mem_read, mem_write}, 2'b00);
          after_resp = 0;
        end
        if ((mem_read || mem_write) && !prev_cmd) begin
          if (exp_q.size() == 0) chk("unexpected_cmd", 1, 0);
          else begin
            mon_e = exp_q[0];
            chk("cmd_cycle", cyc, mon_e.cmd_cyc);
            chk("cmd_kind", {mem_read, mem_write}, mon_e.wr ? 2'b01 : 2'b10);
            chk("cmd_addr", mem_address, mon_e.addr);
            if (mon_e.wr) chk("cmd_wdata", mem_wdata, mon_e.wdata);
          end
        end
        prev_cmd = mem_read || mem_write;
        if (i_resp || d_resp) begin
          if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("resp_side", {i_resp, d_resp}, mon_e.side ? 2'b01 : 2'b10);
            chk("resp_cycle", cyc, mon_e.resp_cyc);
            chk("resp_addr", mem_address, mon_e.addr);
            chk("resp_kind", {mem_read, mem_write}, mon_e.wr ? 2'b01 : 2'b10);
            if (!mon_e.wr) chk("resp_rdata", mon_e.side ? d_rdata : i_rdata, mon_e.rdata);
          end
          if (i_resp) i_seen = 1;
          if (d_resp) d_seen = 1;
          after_resp = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
`ifdef CACHELINE_ARBITER_RR_EN
    tie2_d_first = 0;
`else
    tie2_d_first = 1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    tick();
    rst = 1'b1;
    tick();

    tie(1'b1, 32'h1000, 32'h2000);

    c0 = cyc;
    push(1, 1, 32'h100, {8{32'h12345678}}, c0 + 1, c0 + 1 + mem_lat);
    d_write = 1'b1; d_address = 32'h100; d_wdata = {8{32'h12345678}};
    wait_idle();

    tie(tie2_d_first, 32'h1040, 32'h2040);

    c0 = cyc;
    push(0, 0, 32'h60, '0, c0 + 1, c0 + 1 + mem_lat);
    i_read = 1'b1; i_address = 32'h60;
    wait_idle();

    mem_lat = 6;
    c0 = cyc;
    push(1, 0, 32'h200, '0, c0 + 1, c0 + 1 + mem_lat);
    d_read = 1'b1; d_address = 32'h200;
    repeat (3) tick();
    d_address = 32'h300;
    wait_idle();

    mem_lat = 2;
    c0 = cyc;
    push(1, 1, 32'h400, {16{16'hBEEF}}, c0 + 1, c0 + 1 + mem_lat);
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h400; d_wdata = {16{16'hBEEF}};
    wait_idle();

    mem_lat = 20;
    c0 = cyc;
    push(0, 0, 32'h80, '0, c0 + 1, c0 + 1 + mem_lat);
    i_read = 1'b1; i_address = 32'h80;
    repeat (4) tick();
    #1 chk("busy_before_rst", mem_read, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_mem_read", mem_read, 0);
    chk("arst_i_resp", i_resp, 0);
    chk("arst_d_resp", d_resp, 0);
    exp_q.delete();
    i_read = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    mem_lat = 4;
    c0 = cyc;
    push(0, 0, 32'h80, '0, c0 + 1, c0 + 1 + mem_lat);
    i_read = 1'b1; i_address = 32'h80;
    wait_idle();

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
